// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the integer register file and its scoreboard.
package reg_file_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]          word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, x0 never busy.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);
  logic [NREGS-1:0] busy_nxt;

  // flush beats issue, issue beats writeback (a newer producer is in flight)
  always_comb begin
    busy_nxt = busy_vec;
    for (int i = 0; i < NREGS; i++) begin
      if (flush)                                 busy_nxt[i] = 1'b0;
      else if (iss_valid && (iss_rd == AW'(i)))  busy_nxt[i] = 1'b1;
      else if (we && (waddr == AW'(i)))          busy_nxt[i] = 1'b0;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with NRD combinational read ports, one write port and a busy scoreboard.
// REG_FILE_BYPASS_EN enables write-through of same-cycle writeback data and busy clear.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic                       wr_en;

  assign wr_en = we && (waddr != AW'(ZERO_REG));

  // x0 is never written, so its reset value of zero sticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     regs        <= '0;
    else if (wr_en) regs[waddr] <= wdata;
  end

  reg_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .we       (we),
    .waddr    (waddr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[k*AW +: AW];
`ifdef REG_FILE_BYPASS_EN
    logic hit;
    assign hit = wr_en && (waddr == ra);
    assign rdata[k*XLEN +: XLEN] = hit ? wdata : regs[ra];
    // a same-cycle re-issue keeps the register busy despite the writeback
    assign rbusy[k] = hit ? (iss_valid && (iss_rd == ra)) : busy_vec[ra];
`else
    assign rdata[k*XLEN +: XLEN] = regs[ra];
    assign rbusy[k]              = busy_vec[ra];
`endif
  end
endmodule
